scalar_integer_pipe: RTL and testbench

Parametrised, pipelined successor to the scalar integer functional unit. Performs sum, difference, population count, parity and leading-zero count on WIDTH-bit integers. Each result carries a destination-register tag and an error flag, and the unit supports a pipeline-wide hold. It sits between scalar issue and the Si write-back port, and the issue logic may start one operation per cycle.

---
 rtl/scalar_int_pkg.sv | 17 +
 rtl/sifu_lzc.sv | 31 +++
 rtl/scalar_integer_pipe.sv | 197 +++++++++++++++++++
 tb/tb_scalar_integer_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/scalar_int_pkg.sv
// Opcodes, subfunction codes and result sizing shared by the scalar integer pipe.
package scalar_int_pkg;

  localparam logic [6:0] OP_SUM  = 7'o104;
  localparam logic [6:0] OP_DIFF = 7'o105;
  localparam logic [6:0] OP_POP  = 7'o106;
  localparam logic [6:0] OP_LZC  = 7'o107;

  localparam int SUB_POP = 0;
  localparam int SUB_PAR = 1;

  // Wide enough to hold the value WIDTH itself (all-zero operand).
  function automatic int lzc_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sifu_lzc.sv
// Combinational leading-zero counter, binary tree over a power-of-two WIDTH.
module sifu_lzc import scalar_int_pkg::*; #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]        i_dat,
  output logic [lzc_w(WIDTH)-1:0] o_cnt
);

  localparam int CW   = lzc_w(WIDTH);
  localparam int LVLS = $clog2(WIDTH);

  logic          zero [WIDTH];
  logic [CW-1:0] cnt  [WIDTH];

  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      zero[j] = ~i_dat[j];
      cnt[j]  = '0;
    end
    // Node j merges high child 2j+1 over low child 2j; in-place is safe because
    // every write lands at an index no greater than the ones still to be read.
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (WIDTH >> (l + 1)); j++) begin
        cnt[j]  = zero[2*j+1] ? CW'(1 << l) + cnt[2*j] : cnt[2*j+1];
        zero[j] = zero[2*j+1] & zero[2*j];
      end
    end
    o_cnt = zero[0] ? CW'(WIDTH) : cnt[0];
  end

endmodule

// File: rtl/scalar_integer_pipe.sv
// Pipelined scalar integer unit (sum, difference, pop/parity, LZC) with tag, error and global hold.
// Define SIFU_OVERFLOW_EN to build signed-overflow detection on o_Ovf; otherwise o_Ovf is tied low.
module scalar_integer_pipe import scalar_int_pkg::*; #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_Issue,
  input  logic [6:0]       i_Instr,
  input  logic [WIDTH-1:0] i_Sj,
  input  logic [WIDTH-1:0] i_Sk,
  input  logic [TAG_W-1:0] i_Tag,
  input  logic             i_Hold,
  output logic             o_Ready,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Si,
  output logic [TAG_W-1:0] o_Tag,
  output logic             o_Err,
  output logic             o_Ovf
);

  localparam int LZW = lzc_w(WIDTH);
  localparam int RS  = STAGES - 1;  // stage 2 onward carry results only

  logic             s1_vld_q, s1_vld_d;
  logic [6:0]       s1_op_q,  s1_op_d;
  logic [WIDTH-1:0] s1_sj_q,  s1_sj_d;
  logic [WIDTH-1:0] s1_sk_q,  s1_sk_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             rs_vld_q [RS];
  logic             rs_vld_d [RS];
  logic [WIDTH-1:0] rs_si_q  [RS];
  logic [WIDTH-1:0] rs_si_d  [RS];
  logic [TAG_W-1:0] rs_tag_q [RS];
  logic [TAG_W-1:0] rs_tag_d [RS];
  logic             rs_err_q [RS];
  logic             rs_err_d [RS];

  logic             accept;
  logic             is_diff;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_res;
  logic [LZW-1:0]   pop_lvl [WIDTH];
  logic [LZW-1:0]   lzc_cnt;
  logic [WIDTH-1:0] res;
  logic             err;

  assign o_Ready = !i_Hold && !rst;
  assign accept  = i_Issue && o_Ready;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_op_d  = s1_op_q;
    s1_sj_d  = s1_sj_q;
    s1_sk_d  = s1_sk_q;
    s1_tag_d = s1_tag_q;
    if (!i_Hold) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_op_d  = i_Instr;
        s1_sj_d  = i_Sj;
        s1_sk_d  = i_Sk;
        s1_tag_d = i_Tag;
      end
    end
  end

  // One adder serves both sum and difference (Sj + ~Sk + 1).
  assign is_diff = (s1_op_q == OP_DIFF);
  assign add_b   = is_diff ? ~s1_sk_q : s1_sk_q;
  assign add_res = s1_sj_q + add_b + WIDTH'(is_diff);

  // Pairwise adder tree, reduced in place level by level.
  always_comb begin
    for (int j = 0; j < WIDTH; j++) pop_lvl[j] = LZW'(s1_sj_q[j]);
    for (int l = 0; l < $clog2(WIDTH); l++) begin
      for (int j = 0; j < (WIDTH >> (l + 1)); j++) begin
        pop_lvl[j] = pop_lvl[2*j] + pop_lvl[2*j+1];
      end
    end
  end

  sifu_lzc #(.WIDTH(WIDTH)) u_lzc (
    .i_dat (s1_sj_q),
    .o_cnt (lzc_cnt)
  );

  always_comb begin
    res = '0;
    err = 1'b0;
    if (s1_vld_q) begin
      case (s1_op_q)
        OP_SUM, OP_DIFF: res = add_res;
        OP_POP: begin
          if (s1_sk_q == WIDTH'(SUB_POP))      res = WIDTH'(pop_lvl[0]);
          else if (s1_sk_q == WIDTH'(SUB_PAR)) res = WIDTH'(^s1_sj_q);
          else                                 err = 1'b1;
        end
        OP_LZC:  res = WIDTH'(lzc_cnt);
        default: err = 1'b1;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < RS; k++) begin
      rs_vld_d[k] = rs_vld_q[k];
      rs_si_d[k]  = rs_si_q[k];
      rs_tag_d[k] = rs_tag_q[k];
      rs_err_d[k] = rs_err_q[k];
    end
    if (!i_Hold) begin
      rs_vld_d[0] = s1_vld_q;
      rs_si_d[0]  = res;
      rs_tag_d[0] = s1_vld_q ? s1_tag_q : '0;
      rs_err_d[0] = err;
      for (int k = 1; k < RS; k++) begin
        rs_vld_d[k] = rs_vld_q[k-1];
        rs_si_d[k]  = rs_si_q[k-1];
        rs_tag_d[k] = rs_tag_q[k-1];
        rs_err_d[k] = rs_err_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= '0;
      s1_sj_q  <= '0;
      s1_sk_q  <= '0;
      s1_tag_q <= '0;
      for (int k = 0; k < RS; k++) begin
        rs_vld_q[k] <= 1'b0;
        rs_si_q[k]  <= '0;
        rs_tag_q[k] <= '0;
        rs_err_q[k] <= 1'b0;
      end
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_op_q  <= s1_op_d;
      s1_sj_q  <= s1_sj_d;
      s1_sk_q  <= s1_sk_d;
      s1_tag_q <= s1_tag_d;
      for (int k = 0; k < RS; k++) begin
        rs_vld_q[k] <= rs_vld_d[k];
        rs_si_q[k]  <= rs_si_d[k];
        rs_tag_q[k] <= rs_tag_d[k];
        rs_err_q[k] <= rs_err_d[k];
      end
    end
  end

  assign o_Valid = rs_vld_q[RS-1];
  assign o_Si    = rs_si_q[RS-1];
  assign o_Tag   = rs_tag_q[RS-1];
  assign o_Err   = rs_err_q[RS-1];

`ifdef SIFU_OVERFLOW_EN
  logic ovf;
  logic rs_ovf_q [RS];
  logic rs_ovf_d [RS];

  always_comb begin
    ovf = 1'b0;
    if (s1_vld_q) begin
      if (s1_op_q == OP_SUM)
        ovf = (s1_sj_q[WIDTH-1] == s1_sk_q[WIDTH-1]) && (add_res[WIDTH-1] != s1_sj_q[WIDTH-1]);
      else if (s1_op_q == OP_DIFF)
        ovf = (s1_sj_q[WIDTH-1] != s1_sk_q[WIDTH-1]) && (add_res[WIDTH-1] != s1_sj_q[WIDTH-1]);
    end
  end

  always_comb begin
    for (int k = 0; k < RS; k++) rs_ovf_d[k] = rs_ovf_q[k];
    if (!i_Hold) begin
      rs_ovf_d[0] = ovf;
      for (int k = 1; k < RS; k++) rs_ovf_d[k] = rs_ovf_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < RS; k++) begin
      if (rst) rs_ovf_q[k] <= 1'b0;
      else     rs_ovf_q[k] <= rs_ovf_d[k];
    end
  end

  assign o_Ovf = rs_ovf_q[RS-1];
`else
  assign o_Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_scalar_integer_pipe.sv
// Directed scoreboard bench for scalar_integer_pipe (WIDTH=64, STAGES=2, TAG_W=3).
module tb_scalar_integer_pipe;

  localparam int STAGES = 2;
`ifdef SIFU_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] si;
    logic [2:0]  tag;
    logic        err;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk, rst;
  logic        i_Issue, i_Hold;
  logic [6:0]  i_Instr;
  logic [63:0] i_Sj, i_Sk;
  logic [2:0]  i_Tag;
  logic        o_Ready, o_Valid, o_Err, o_Ovf;
  logic [63:0] o_Si;
  logic [2:0]  o_Tag;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_cnt = 0;
  exp_t sb[$];

  scalar_integer_pipe #(.WIDTH(64), .STAGES(STAGES), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .i_Issue(i_Issue), .i_Instr(i_Instr), .i_Sj(i_Sj),
    .i_Sk(i_Sk), .i_Tag(i_Tag), .i_Hold(i_Hold), .o_Ready(o_Ready),
    .o_Valid(o_Valid), .o_Si(o_Si), .o_Tag(o_Tag), .o_Err(o_Err), .o_Ovf(o_Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_bad=%0d)", n_bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic exp_t model(input logic [6:0] op, input logic [63:0] sj, input logic [63:0] sk);
    exp_t e;
    logic [63:0] r;
    int n;
    e.si = '0; e.err = 1'b0; e.ovf = 1'b0; e.tag = '0; e.cyc = -1;
    case (op)
      7'o104: begin
        r = sj + sk; e.si = r;
        e.ovf = OVF_EN && (sj[63] == sk[63]) && (r[63] != sj[63]);
      end
      7'o105: begin
        r = sj - sk; e.si = r;
        e.ovf = OVF_EN && (sj[63] != sk[63]) && (r[63] != sj[63]);
      end
      7'o106: begin
        if (sk == 64'd0)      e.si = 64'($countones(sj));
        else if (sk == 64'd1) e.si = {63'd0, ^sj};
        else                  e.err = 1'b1;
      end
      7'o107: begin
        n = 64;
        for (int b = 0; b < 64; b++) if (sj[b]) n = 63 - b;
        e.si = 64'(n);
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic go(input logic iss, input logic [6:0] op, input logic [63:0] sj,
                    input logic [63:0] sk, input logic [2:0] tag, input logic hold, input bit timed);
    exp_t e;
    i_Issue = iss; i_Instr = op; i_Sj = sj; i_Sk = sk; i_Tag = tag; i_Hold = hold;
    #1;
    chk("o_Ready", o_Ready, !hold && !rst);
    if (iss && !hold && !rst) begin
      e = model(op, sj, sk);
      e.tag = tag;
      e.cyc = timed ? cyc_cnt + STAGES : -1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 7'o0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    chk(tag, sb.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, o_Valid, 1'b0);
    chk({tag, "_si"},    o_Si,    64'd0);
    chk({tag, "_tag"},   o_Tag,   3'd0);
    chk({tag, "_err"},   o_Err,   1'b0);
    chk({tag, "_ovf"},   o_Ovf,   1'b0);
  endtask

  // Output monitor: checks hold stability and consumes results when not held.
  logic        prev_hold = 1'b0;
  logic        p_vld, p_err, p_ovf;
  logic [63:0] p_si;
  logic [2:0]  p_tag;
  exp_t        m_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) begin
        chk("hold_valid", o_Valid, p_vld);
        chk("hold_si",    o_Si,    p_si);
        chk("hold_tag",   o_Tag,   p_tag);
        chk("hold_err",   o_Err,   p_err);
        chk("hold_ovf",   o_Ovf,   p_ovf);
      end
      if (o_Valid && !i_Hold) begin
        chk("spurious_valid", sb.size() == 0, 1'b0);
        if (sb.size() != 0) begin
          m_e = sb.pop_front();
          chk("si",  o_Si,  m_e.si);
          chk("tag", o_Tag, m_e.tag);
          chk("err", o_Err, m_e.err);
          chk("ovf", o_Ovf, m_e.ovf);
          if (m_e.cyc >= 0) chk("latency", cyc_cnt, m_e.cyc);
        end
      end
    end
    prev_hold = i_Hold && !rst;
    p_vld = o_Valid; p_si = o_Si; p_tag = o_Tag; p_err = o_Err; p_ovf = o_Ovf;
  end

  initial begin
    logic [6:0]  r_op;
    logic [63:0] r_sk;
    rst = 1'b1; i_Issue = 1'b0; i_Hold = 1'b0; i_Instr = '0; i_Sj = '0; i_Sk = '0; i_Tag = '0;
    @(posedge clk); #1;
    chk_zero_outputs("reset");
    chk("reset_ready", o_Ready, 1'b0);
    idle(1);
    rst = 1'b0;

    go(1'b1, 7'o104, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd3, 1'b0, 1'b1);
    go(1'b1, 7'o105, 64'd5, 64'd7, 3'd1, 1'b0, 1'b1);
    go(1'b1, 7'o106, 64'hF0F0_F0F0_F0F0_F0F0, 64'd0, 3'd2, 1'b0, 1'b1);
    go(1'b1, 7'o106, 64'd7, 64'd1, 3'd4, 1'b0, 1'b1);
    go(1'b1, 7'o106, 64'd7, 64'd2, 3'd5, 1'b0, 1'b1);
    go(1'b1, 7'o107, 64'd0, 64'd0, 3'd6, 1'b0, 1'b1);
    go(1'b1, 7'o107, 64'd1, 64'd0, 3'd7, 1'b0, 1'b1);
    go(1'b1, 7'o107, 64'h8000_0000_0000_0000, 64'd0, 3'd0, 1'b0, 1'b1);
    go(1'b1, 7'o107, 64'h0000_0001_0000_0000, 64'd0, 3'd1, 1'b0, 1'b1);
    go(1'b1, 7'o110, 64'd9, 64'd9, 3'd2, 1'b0, 1'b1);
    go(1'b1, 7'o105, 64'h8000_0000_0000_0000, 64'd1, 3'd3, 1'b0, 1'b1);
    drain("drain_directed");

    for (int i = 0; i < 16; i++) begin
      r_op = 7'o104 + 7'($urandom_range(0, 3));
      r_sk = (r_op == 7'o106) ? 64'($urandom_range(0, 2)) : {$urandom, $urandom};
      go(1'($urandom_range(0, 1)), r_op, {$urandom, $urandom}, r_sk, 3'($urandom), 1'b0, 1'b1);
    end
    drain("drain_random");

    go(1'b1, 7'o104, 64'd10, 64'd1, 3'd1, 1'b0, 1'b0);
    go(1'b1, 7'o104, 64'd20, 64'd2, 3'd2, 1'b0, 1'b0);
    go(1'b1, 7'o104, 64'd30, 64'd3, 3'd3, 1'b1, 1'b0);
    go(1'b1, 7'o104, 64'd40, 64'd4, 3'd4, 1'b1, 1'b0);
    go(1'b1, 7'o104, 64'd30, 64'd3, 3'd3, 1'b1, 1'b0);
    go(1'b1, 7'o104, 64'd30, 64'd3, 3'd3, 1'b0, 1'b0);
    go(1'b1, 7'o104, 64'd40, 64'd4, 3'd4, 1'b0, 1'b0);
    drain("drain_hold");

    go(1'b1, 7'o104, 64'd100, 64'd1, 3'd5, 1'b0, 1'b0);
    go(1'b1, 7'o105, 64'd100, 64'd1, 3'd6, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    go(1'b1, 7'o104, 64'd1, 64'd1, 3'd7, 1'b0, 1'b0);
    chk_zero_outputs("midreset");
    rst = 1'b0;
    idle(4);
    go(1'b1, 7'o107, 64'h0000_0000_0000_00FF, 64'd0, 3'd7, 1'b0, 1'b1);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
